wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_arbiter.sv | 116 +++++++++++
 tb/tb_wb_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back port bundle: WB-stage request, MDU result handshake, RF write.
// master drives pipe_wb_*/mdu_valid/rd/data; slave (the arbiter) drives the rest.
interface wb_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              pipe_wb_valid;
    logic [4:0]        pipe_wb_rd;
    logic [DATA_W-1:0] pipe_wb_data;
    logic              pipe_stall;

    logic              mdu_valid;
    logic [4:0]        mdu_rd;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        input  pipe_stall,
        output mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        output pipe_stall,
        input  mdu_valid, mdu_rd, mdu_data,
        output mdu_ready,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_arbiter.sv
// Arbitrates the single RF write port between the WB stage and a FIFO of MDU results.
// Ports: clk, reset (async, active-low), bus (wb_arbiter_if.slave).
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    wb_arbiter_if.slave    bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    logic [4:0]        fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve_cnt;

    logic              empty;
    logic              push;
    logic              pop;
    logic              grant_mdu;
    logic              grant_pipe;
    logic [4:0]        head_rd;
    logic [DATA_W-1:0] head_data;

    assign empty     = (count == '0);
    assign head_rd   = fifo_rd[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // Ready comes only from registered occupancy, so a full FIFO
    // never accepts in the same cycle it pops.
    assign bus.mdu_ready = (count < CNT_FULL);
    assign push          = bus.mdu_valid && bus.mdu_ready;

    // MDU wins when the pipe is idle or has bypassed the head too long.
    assign grant_mdu  = !empty &&
                        (!bus.pipe_wb_valid || starve_cnt == STV_MAX);
    assign grant_pipe = bus.pipe_wb_valid && !grant_mdu;
    assign pop        = grant_mdu;

    assign bus.pipe_stall = bus.pipe_wb_valid && grant_mdu;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.mdu_rd;
            fifo_data[wr_ptr] <= bus.mdu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (empty || grant_mdu) begin
            starve_cnt <= '0;
        end else if (grant_pipe && starve_cnt != STV_MAX) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // Writes to x0 are consumed at grant but never raise rf_we.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            bus.rf_we <= 1'b0;
            unique case (1'b1)
                grant_mdu: begin
                    bus.rf_we    <= (head_rd != 5'd0);
                    bus.rf_waddr <= head_rd;
                    bus.rf_wdata <= head_data;
                end
                grant_pipe: begin
                    bus.rf_we    <= (bus.pipe_wb_rd != 5'd0);
                    bus.rf_waddr <= bus.pipe_wb_rd;
                    bus.rf_wdata <= bus.pipe_wb_data;
                end
                default: begin
                    bus.rf_waddr <= bus.rf_waddr;
                    bus.rf_wdata <= bus.rf_wdata;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, pipe, MDU, starvation, full, x0, mid-reset.
// Drives bus inputs #1 after posedge; samples registered outputs there too.
module tb_wb_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    wb_arbiter_if #(.DATA_W(32)) bus ();

    wb_arbiter #(
        .DATA_W(32),
        .FIFO_DEPTH(2),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_wb_valid = 1'b0;
        bus.pipe_wb_rd    = 5'd0;
        bus.pipe_wb_data  = 32'h0;
        bus.mdu_valid     = 1'b0;
        bus.mdu_rd        = 5'd0;
        bus.mdu_data      = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_rd    = 5'd3;
        cyc();
        cyc();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_we got=%0b want=0", bus.rf_we);
        end
        checks++;
        if (bus.rf_waddr !== 5'd0) begin
            failures++;
            $display("FAIL rst_waddr got=%0d want=0", bus.rf_waddr);
        end
        checks++;
        if (bus.rf_wdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_wdata got=%h want=0", bus.rf_wdata);
        end
        checks++;
        if (bus.mdu_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready got=%0b want=1", bus.mdu_ready);
        end
        checks++;
        if (bus.pipe_stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_stall got=%0b want=0", bus.pipe_stall);
        end
        checks++;
        if (dut.starve_cnt !== '0) begin
            failures++;
            $display("FAIL rst_starve got=%0d want=0", dut.starve_cnt);
        end
        idle_inputs();
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_pipe_only();
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_rd    = 5'd5;
        bus.pipe_wb_data  = 32'h1234;
        #1;
        checks++;
        if (bus.pipe_stall !== 1'b0) begin
            failures++;
            $display("FAIL pipe_stall got=%0b want=0", bus.pipe_stall);
        end
        cyc();
        bus.pipe_wb_valid = 1'b0;
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 ||
            bus.rf_wdata !== 32'h1234) begin
            failures++;
            $display("FAIL pipe_write got=%0b/%0d/%h want=1/5/1234",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        cyc();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd5 ||
            bus.rf_wdata !== 32'h1234) begin
            failures++;
            $display("FAIL pipe_hold got=%0b/%0d/%h want=0/5/1234",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
    endtask

    task automatic test_mdu_only();
        bus.mdu_valid = 1'b1;
        bus.mdu_rd    = 5'd7;
        bus.mdu_data  = 32'hDEAD;
        #1;
        checks++;
        if (bus.mdu_ready !== 1'b1) begin
            failures++;
            $display("FAIL mdu_ready got=%0b want=1", bus.mdu_ready);
        end
        cyc();
        bus.mdu_valid = 1'b0;
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL mdu_no_bypass got=%0b want=0", bus.rf_we);
        end
        cyc();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 ||
            bus.rf_wdata !== 32'hDEAD) begin
            failures++;
            $display("FAIL mdu_write got=%0b/%0d/%h want=1/7/dead",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        cyc();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL mdu_once got=%0b want=0", bus.rf_we);
        end
    endtask

    task automatic test_starvation();
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_rd    = 5'd1;
        bus.pipe_wb_data  = 32'h100;
        bus.mdu_valid     = 1'b1;
        bus.mdu_rd        = 5'd9;
        bus.mdu_data      = 32'h99;
        cyc();
        bus.mdu_valid = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            bus.pipe_wb_rd   = 5'(i);
            bus.pipe_wb_data = 32'(i * 256);
            #1;
            checks++;
            if (bus.pipe_stall !== 1'b0) begin
                failures++;
                $display("FAIL starve_stall%0d got=%0b want=0",
                         i, bus.pipe_stall);
            end
            cyc();
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(i) ||
                bus.rf_wdata !== 32'(i * 256)) begin
                failures++;
                $display("FAIL starve_pipe%0d got=%0b/%0d/%h want=1/%0d/%h",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata,
                         i, i * 256);
            end
        end
        bus.pipe_wb_rd   = 5'd6;
        bus.pipe_wb_data = 32'h600;
        #1;
        checks++;
        if (bus.pipe_stall !== 1'b1) begin
            failures++;
            $display("FAIL starve_stall got=%0b want=1", bus.pipe_stall);
        end
        cyc();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 ||
            bus.rf_wdata !== 32'h99) begin
            failures++;
            $display("FAIL starve_mdu got=%0b/%0d/%h want=1/9/99",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        checks++;
        if (dut.starve_cnt !== '0) begin
            failures++;
            $display("FAIL starve_clear got=%0d want=0", dut.starve_cnt);
        end
        #1;
        checks++;
        if (bus.pipe_stall !== 1'b0) begin
            failures++;
            $display("FAIL starve_unstall got=%0b want=0", bus.pipe_stall);
        end
        cyc();
        bus.pipe_wb_valid = 1'b0;
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd6 ||
            bus.rf_wdata !== 32'h600) begin
            failures++;
            $display("FAIL starve_resume got=%0b/%0d/%h want=1/6/600",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        cyc();
    endtask

    task automatic test_full();
        int addr_q[$];
        int data_q[$];
        bit accepted;
        bit stall_seen;
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_rd    = 5'd10;
        bus.pipe_wb_data  = 32'hA0;
        bus.mdu_valid     = 1'b1;
        bus.mdu_rd        = 5'd11;
        bus.mdu_data      = 32'hB11;
        cyc();
        bus.mdu_rd   = 5'd12;
        bus.mdu_data = 32'hB12;
        cyc();
        bus.mdu_rd   = 5'd13;
        bus.mdu_data = 32'hB13;
        #1;
        checks++;
        if (bus.mdu_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready got=%0b want=0", bus.mdu_ready);
        end
        accepted   = 1'b0;
        stall_seen = 1'b0;
        for (int n = 0; n < 60 && addr_q.size() < 3; n++) begin
            #1;
            if (bus.pipe_stall && !stall_seen) begin
                stall_seen = 1'b1;
                checks++;
                if (bus.mdu_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL full_passthru got=%0b want=0",
                             bus.mdu_ready);
                end
            end
            if (bus.mdu_valid && bus.mdu_ready) accepted = 1'b1;
            cyc();
            if (accepted) bus.mdu_valid = 1'b0;
            if (bus.rf_we && bus.rf_waddr != 5'd10) begin
                addr_q.push_back(int'(bus.rf_waddr));
                data_q.push_back(int'(bus.rf_wdata));
            end
        end
        bus.pipe_wb_valid = 1'b0;
        bus.mdu_valid     = 1'b0;
        checks++;
        if (addr_q.size() != 3) begin
            failures++;
            $display("FAIL full_count got=%0d want=3", addr_q.size());
        end else begin
            checks++;
            if (addr_q[0] != 11 || addr_q[1] != 12 || addr_q[2] != 13) begin
                failures++;
                $display("FAIL full_order got=%0d,%0d,%0d want=11,12,13",
                         addr_q[0], addr_q[1], addr_q[2]);
            end
            checks++;
            if (data_q[0] != 32'hB11 || data_q[1] != 32'hB12 ||
                data_q[2] != 32'hB13) begin
                failures++;
                $display("FAIL full_data got=%h,%h,%h want=b11,b12,b13",
                         data_q[0], data_q[1], data_q[2]);
            end
        end
        checks++;
        if (accepted !== 1'b1 || stall_seen !== 1'b1) begin
            failures++;
            $display("FAIL full_flow got=acc%0b/stall%0b want=acc1/stall1",
                     accepted, stall_seen);
        end
        cyc();
        cyc();
    endtask

    task automatic test_rd_zero();
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_rd    = 5'd0;
        bus.pipe_wb_data  = 32'h55;
        #1;
        checks++;
        if (bus.pipe_stall !== 1'b0) begin
            failures++;
            $display("FAIL x0_pipe_stall got=%0b want=0", bus.pipe_stall);
        end
        cyc();
        bus.pipe_wb_valid = 1'b0;
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL x0_pipe_we got=%0b want=0", bus.rf_we);
        end
        bus.mdu_valid = 1'b1;
        bus.mdu_rd    = 5'd0;
        bus.mdu_data  = 32'h77;
        cyc();
        bus.mdu_valid = 1'b0;
        cyc();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL x0_mdu_we got=%0b want=0", bus.rf_we);
        end
        checks++;
        if (dut.count !== '0) begin
            failures++;
            $display("FAIL x0_mdu_pop got=%0d want=0", dut.count);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        int writes;
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_rd    = 5'd10;
        bus.pipe_wb_data  = 32'hA0;
        bus.mdu_valid     = 1'b1;
        bus.mdu_rd        = 5'd20;
        bus.mdu_data      = 32'hC20;
        cyc();
        bus.mdu_rd   = 5'd21;
        bus.mdu_data = 32'hC21;
        cyc();
        bus.mdu_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.mdu_ready !== 1'b1 ||
            bus.pipe_stall !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst got=we%0b/rdy%0b/stl%0b want=0/1/0",
                     bus.rf_we, bus.mdu_ready, bus.pipe_stall);
        end
        checks++;
        if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_rst_rf got=%0d/%h want=0/0",
                     bus.rf_waddr, bus.rf_wdata);
        end
        cyc();
        cyc();
        bus.pipe_wb_valid = 1'b0;
        reset = 1'b1;
        writes = 0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            if (bus.rf_we) writes++;
        end
        checks++;
        if (writes != 0) begin
            failures++;
            $display("FAIL mid_rst_discard got=%0d want=0", writes);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle_inputs();
        test_reset();
        test_pipe_only();
        test_mdu_only();
        test_starvation();
        test_full();
        test_rd_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=done");
        $fatal(1, "timeout");
    end
endmodule
